// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered-read mode.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_TH      = 14,
    parameter int AE_TH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_req,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_TH_C = AF_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_TH_C = AE_TH[ADDR_WIDTH:0];

    if (!((AE_TH < AF_TH) && (AF_TH <= DEPTH))) begin : g_bad_cfg
        $error("sync_fifo_ctrl: thresholds must satisfy AE_TH < AF_TH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH:0]   count;

    assign wr_idx = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_idx = rd_ptr_q[ADDR_WIDTH-1:0];

    // Status is decoded purely from registered pointers, so it only moves on edges.
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) && (wr_idx == rd_idx);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;

    assign wr_acc = wr_req && !full;
    assign rd_acc = rd_req && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A new error event in the same cycle takes priority over the clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_req && full) begin
            overflow_d = 1'b1;
        end
        if (rd_req && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_idx] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head of queue is presented combinationally from the array; rd_req acts as a pop.
    assign data_out = empty ? '0 : mem_q[rd_idx];
    assign rd_valid = !empty;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                data_out_q <= mem_q[rd_idx];
            end
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
`endif

    assign fifo_full    = full;
    assign fifo_empty   = empty;
    assign fill_count   = count;
    assign almost_full  = (count >= AF_TH_C);
    assign almost_empty = (count <= AE_TH_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl; exercises registered-read mode by default and
// the first-word-fall-through path when FIFO_FWFT_EN is defined.
module tb_sync_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [31:0] data_in;
    logic        rd_req;
    logic        clr_err;
    logic [31:0] data_out;
    logic        rd_valid;
    logic        fifo_full;
    logic        fifo_empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  fill_count;
    logic        overflow;
    logic        underflow;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_TH(14), .AE_TH(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .data_in(data_in), .rd_req(rd_req),
        .clr_err(clr_err), .data_out(data_out), .rd_valid(rd_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .fill_count(fill_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_req = 1'b0; rd_req = 1'b0; clr_err = 1'b0; data_in = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", fifo_empty); end
        n_vec++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL rst_aempty got %b want 1", almost_empty); end
        n_vec++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", fifo_full); end
        n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_afull got %b want 0", almost_full); end
        n_vec++; if (fill_count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", fill_count); end
        rst = 1'b0;
        step();
        n_vec++; if (data_out !== 32'h0) begin n_err++; $display("FAIL rst_dout got %h want 0", data_out); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got %b want 0", rd_valid); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_udf got %b want 0", underflow); end
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL idle_empty got %b want 1", fifo_empty); end
    endtask

`ifndef FIFO_FWFT_EN
    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_req = 1'b1; data_in = 32'(i);
            step();
            n_vec++; if (fill_count !== 5'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, fill_count, i); end
            n_vec++; if (almost_full !== (i >= 14)) begin n_err++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i >= 14)); end
            n_vec++; if (almost_empty !== (i <= 2)) begin n_err++; $display("FAIL fill_aempty[%0d] got %b want %b", i, almost_empty, (i <= 2)); end
            n_vec++; if (fifo_full !== (i == 16)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, fifo_full, (i == 16)); end
        end
        data_in = 32'h11;
        step();
        wr_req = 1'b0;
        n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", fifo_full); end
        n_vec++; if (fill_count !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", fill_count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL ovf_udf got %b want 0", underflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rd_req = 1'b1;
            step();
            rd_req = 1'b0;
            n_vec++; if (data_out !== 32'(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, data_out, i); end
            n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got %b want 1", i, rd_valid); end
            n_vec++; if (fill_count !== 5'(16 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, fill_count, 16 - i); end
            step();
            n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL drain_vdrop[%0d] got %b want 0", i, rd_valid); end
            n_vec++; if (data_out !== 32'(i)) begin n_err++; $display("FAIL drain_hold[%0d] got %h want %h", i, data_out, i); end
        end
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", fifo_empty); end
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag got %b want 1", underflow); end
        n_vec++; if (data_out !== 32'h10) begin n_err++; $display("FAIL udf_dout got %h want 10", data_out); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_valid got %b want 0", rd_valid); end
        n_vec++; if (fill_count !== 5'd0) begin n_err++; $display("FAIL udf_count got %0d want 0", fill_count); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b want 0", overflow); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL clr_udf got %b want 0", underflow); end
    endtask

    task automatic test_stream_wrap();
        for (int k = 0; k < 8; k++) begin
            wr_req = 1'b1; data_in = 32'h100 + 32'(k);
            step();
        end
        n_vec++; if (fill_count !== 5'd8) begin n_err++; $display("FAIL wrap_prefill got %0d want 8", fill_count); end
        for (int k = 8; k < 40; k++) begin
            wr_req = 1'b1; rd_req = 1'b1; data_in = 32'h100 + 32'(k);
            step();
            n_vec++; if (data_out !== 32'h100 + 32'(k - 8)) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", k, data_out, 32'h100 + 32'(k - 8)); end
            n_vec++; if (fill_count !== 5'd8) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 8", k, fill_count); end
            n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d] got %b want 1", k, rd_valid); end
        end
        wr_req = 1'b0;
        for (int k = 32; k < 40; k++) begin
            step();
            n_vec++; if (data_out !== 32'h100 + 32'(k)) begin n_err++; $display("FAIL wrap_tail[%0d] got %h want %h", k, data_out, 32'h100 + 32'(k)); end
        end
        rd_req = 1'b0;
        step();
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b want 1", fifo_empty); end
        n_vec++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL wrap_errs got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            wr_req = 1'b1; data_in = 32'h200 + 32'(k);
            step();
        end
        rd_req = 1'b1; data_in = 32'hDEAD;
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        n_vec++; if (fill_count !== 5'd15) begin n_err++; $display("FAIL full_rw_count got %0d want 15", fill_count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_rw_ovf got %b want 1", overflow); end
        n_vec++; if (data_out !== 32'h200) begin n_err++; $display("FAIL full_rw_dout got %h want 200", data_out); end
        n_vec++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL full_rw_full got %b want 0", fifo_full); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_rw_clr got %b want 0", overflow); end
        rd_req = 1'b1;
        for (int k = 1; k < 16; k++) begin
            step();
            n_vec++; if (data_out !== 32'h200 + 32'(k)) begin n_err++; $display("FAIL full_rw_drain[%0d] got %h want %h", k, data_out, 32'h200 + 32'(k)); end
        end
        rd_req = 1'b0;
        step();
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL full_rw_empty got %b want 1", fifo_empty); end
        // Both requests while empty: write lands, read is refused.
        wr_req = 1'b1; rd_req = 1'b1; data_in = 32'h33;
        step();
        wr_req = 1'b0; rd_req = 1'b0;
        n_vec++; if (fill_count !== 5'd1) begin n_err++; $display("FAIL empty_rw_count got %0d want 1", fill_count); end
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL empty_rw_udf got %b want 1", underflow); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_rw_valid got %b want 0", rd_valid); end
        clr_err = 1'b1; rd_req = 1'b1;
        step();
        clr_err = 1'b0; rd_req = 1'b0;
        n_vec++; if (data_out !== 32'h33) begin n_err++; $display("FAIL empty_rw_data got %h want 33", data_out); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL empty_rw_clr got %b want 0", underflow); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            wr_req = 1'b1; data_in = 32'h50 + 32'(k);
            step();
        end
        wr_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (fill_count !== 5'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", fill_count); end
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty got %b want 1", fifo_empty); end
        step();
        rst = 1'b0;
        wr_req = 1'b1; data_in = 32'h77;
        step();
        wr_req = 1'b0; rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        n_vec++; if (data_out !== 32'h77) begin n_err++; $display("FAIL mid_rst_data got %h want 77", data_out); end
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_after got %b want 1", fifo_empty); end
    endtask
`else
    task automatic test_fwft();
        wr_req = 1'b1; data_in = 32'hA5;
        step();
        wr_req = 1'b0;
        n_vec++; if (data_out !== 32'hA5) begin n_err++; $display("FAIL fwft_data got %h want a5", data_out); end
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL fwft_valid got %b want 1", rd_valid); end
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        n_vec++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL fwft_empty got %b want 1", fifo_empty); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL fwft_vdrop got %b want 0", rd_valid); end
        wr_req = 1'b1; data_in = 32'hB1;
        step();
        data_in = 32'hB2;
        step();
        wr_req = 1'b0;
        n_vec++; if (data_out !== 32'hB1) begin n_err++; $display("FAIL fwft_head got %h want b1", data_out); end
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        n_vec++; if (data_out !== 32'hB2) begin n_err++; $display("FAIL fwft_next got %h want b2", data_out); end
        n_vec++; if (fill_count !== 5'd1) begin n_err++; $display("FAIL fwft_count got %0d want 1", fill_count); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef FIFO_FWFT_EN
        test_fwft();
`else
        test_fill();
        test_drain();
        test_stream_wrap();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
